// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file (rf_mp_sb, rf_sb).
// Optional same-cycle write-to-read bypass is enabled with the RF_BYPASS_EN macro.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_DW_DEF    = 32;
    localparam int RF_DEPTH_DEF = 32;

    // LSB position of port idx inside a packed vector of w-bit fields
    function automatic int lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_sb.sv
// Pending-write scoreboard: one busy bit per register, set by alloc, cleared by writes.
// Register 0 is never busy; alloc beats a same-cycle write since it names a newer producer.
module rf_sb
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_WR = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic                 alloc_en_i,
    input  logic [AW-1:0]        alloc_addr_i,
    output logic [DEPTH-1:0]     busy_o
);

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j]) busy_d[wr_addr_i[lsb(j, AW) +: AW]] = 1'b0;
            end
            if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Parametrised multi-port register file with post-reset clear engine and scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_mp_sb
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW_DEF,
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic [DEPTH-1:0]     busy_vec,
    output logic                 init_done
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          init_done_q, init_done_d;
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d     = READY;
                init_done_d = 1'b1;
            end
        end
    end

    // Entry 0 is never stored; reads of it are forced to zero below.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[lsb(j, AW) +: AW] != '0)
                        mem_q[wr_addr[lsb(j, AW) +: AW]] <= wr_data[lsb(j, DW) +: DW];
                end
            end
        end
    end

    rf_sb #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q == READY),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .busy_o       (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;
        logic          rbusy;

        assign ra = rd_addr[lsb(i, AW) +: AW];

        always_comb begin
            rdat  = '0;
            rbusy = 1'b0;
            if (state_q == READY && ra != '0) begin
                rdat  = mem_q[ra];
                rbusy = busy_vec[ra];
`ifdef RF_BYPASS_EN
                // Later ports override earlier ones, matching write priority.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[lsb(j, AW) +: AW] == ra) begin
                        rdat  = wr_data[lsb(j, DW) +: DW];
                        rbusy = alloc_en && (alloc_addr == ra);
                    end
                end
`endif
            end
        end

        assign rd_data[lsb(i, DW) +: DW] = rdat;
        assign rd_busy[i]                = rbusy;
    end

    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed self-checking bench for rf_mp_sb (default parameters, either RF_BYPASS_EN setting).
module tb_rf_mp_sb;

    localparam int DW = 32, DEPTH = 32, AW = 5, NRD = 2, NWR = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*DW-1:0]    rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*DW-1:0]    wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic [DEPTH-1:0]     busy_vec;
    logic                 init_done;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    rf_mp_sb #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        repeat (3) tick();
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_busy_vec", 64'(busy_vec), 64'd0);

        // Release reset while hammering writes/allocs that must be ignored in CLEAR
        rst = 1'b0;
        set_wr(0, 1'b1, 5'd5, 32'h55);
        set_wr(1, 1'b1, 5'd6, 32'h66);
        alloc_en = 1'b1; alloc_addr = 5'd6;
        set_rd(0, 5'd5); set_rd(1, 5'd6);
        tick(); tick();
        chk("clear_rd_data", 64'(rd_data), 64'd0);
        chk("clear_rd_busy", 64'(rd_busy), 64'd0);
        chk("clear_init_low", 64'(init_done), 64'd0);
        wait_init(cnt);
        chk("clear_cycles", 64'(cnt + 2), 64'd31);
        wr_en = '0; alloc_en = 1'b0;
        #1;

        for (int k = 0; k < DEPTH; k++) begin
            set_rd(0, AW'(k)); set_rd(1, AW'(DEPTH - 1 - k));
            #1;
            chk("clear_all_zero", 64'(rd_data), 64'd0);
        end
        chk("clear_busy_none", 64'(busy_vec), 64'd0);
        set_rd(0, 5'd6);
        #1;
        chk("clear_ignored_alloc", 64'(rd_busy[0]), 64'd0);

        // Reset from READY, then pulse reset again at clear cycle 10
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rerst_init_low", 64'(init_done), 64'd0);
        repeat (10) tick();
        chk("mid_clear_init_low", 64'(init_done), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        wait_init(cnt);
        chk("mid_clear_restart", 64'(cnt), 64'd31);

        // Write then read
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5);
        tick();
        wr_en = '0;
        #1;
        chk("wr_rd_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);

        set_wr(0, 1'b1, 5'd0, 32'h1234);
        tick();
        wr_en = '0;
        set_rd(1, 5'd0);
        #1;
        chk("r0_reads_zero", 64'(rd_data[63:32]), 64'd0);

        // Collision: higher port wins
        set_wr(0, 1'b1, 5'd7, 32'h11);
        set_wr(1, 1'b1, 5'd7, 32'h22);
        tick();
        wr_en = '0;
        set_rd(1, 5'd7);
        #1;
        chk("collision_r7", 64'(rd_data[63:32]), 64'h22);
        chk("dual_read", 64'(rd_data), {32'h22, 32'hDEADBEEF});

        // Scoreboard
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        alloc_en = 1'b0;
        set_rd(0, 5'd9);
        #1;
        chk("alloc_r9", 64'(busy_vec), 64'h200);
        chk("alloc_rd_busy", 64'(rd_busy), 64'b01);

        set_wr(1, 1'b1, 5'd9, 32'h99);
        tick();
        wr_en = '0;
        #1;
        chk("write_clears_r9", 64'(busy_vec), 64'd0);
        chk("write_r9_data", 64'(rd_data[31:0]), 64'h99);

        alloc_en = 1'b1; alloc_addr = 5'd9;
        set_wr(0, 1'b1, 5'd9, 32'h98);
        tick();
        alloc_en = 1'b0; wr_en = '0;
        #1;
        chk("alloc_wins", 64'(busy_vec), 64'h200);

        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        alloc_en = 1'b0;
        #1;
        chk("realloc_busy", 64'(busy_vec), 64'h200);

        alloc_en = 1'b1; alloc_addr = 5'd0;
        tick();
        alloc_en = 1'b0;
        #1;
        chk("alloc_r0_ignored", 64'(busy_vec), 64'h200);

        set_wr(0, 1'b1, 5'd5, 32'h77);
        tick();
        wr_en = '0;
        #1;
        chk("write_nonbusy", 64'(busy_vec), 64'h200);

        // Bypass / no-bypass behaviour
        set_wr(0, 1'b1, 5'd3, 32'hA);
        tick();
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_en = 1'b0;
        set_wr(1, 1'b1, 5'd3, 32'hB);
        wr_en[0] = 1'b0;
        set_rd(0, 5'd3);
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_data", 64'(rd_data[31:0]), 64'hB);
        chk("bypass_busy", 64'(rd_busy[0]), 64'd0);
`else
        chk("nobypass_data", 64'(rd_data[31:0]), 64'hA);
        chk("nobypass_busy", 64'(rd_busy[0]), 64'd1);
`endif
        tick();
        wr_en = '0;
        #1;
        chk("bypass_next", 64'(rd_data[31:0]), 64'hB);
        chk("bypass_next_busy", 64'(rd_busy[0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
